// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the PC and fetches one instruction at a time from imem, holding it until decode accepts it
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_o,
  input  logic [31:0] pcplus4_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        stall_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        misalign_o
);
  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;
  state_t state, state_nxt;
  logic drop, redir, hs, rsp, adv;
  assign redir = branch_taken_i & ~|branch_target_i[1:0];
  assign hs = (state == REQ) & imem_req_ready_i;
  assign rsp = (state == WAIT) & imem_rsp_valid_i;
  assign adv = (state == HOLD) & instr_ready_i & ~stall_i;
  assign imem_req_valid_o = state == REQ;
  assign imem_req_addr_o = pc_o;
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT: state_nxt = REQ;
      REQ:  state_nxt = hs ? WAIT : REQ;
      WAIT: state_nxt = imem_rsp_valid_i ? ((drop | redir) ? REQ : HOLD) : WAIT;
      HOLD: state_nxt = (redir | adv) ? REQ : HOLD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BOOT;
      drop <= 1'b0;
      pc_o <= RESET_PC;
      instr_valid_o <= 1'b0;
      instr_o <= NOP_INSTR;
      instr_pc_o <= 32'h0;
      misalign_o <= 1'b0;
    end else begin
      state <= state_nxt;
      misalign_o <= branch_taken_i & |branch_target_i[1:0];
      // a redirect while a request is in flight marks its response as stale
      if (rsp) drop <= 1'b0;
      else if (redir & (hs | state == WAIT)) drop <= 1'b1;
      if (redir) begin
        pc_o <= branch_target_i;
        instr_valid_o <= 1'b0;
        instr_o <= NOP_INSTR;
      end else if (rsp & ~drop) begin
        instr_valid_o <= 1'b1;
        instr_o <= imem_rsp_data_i;
        instr_pc_o <= pc_o;
      end else if (adv) begin
        pc_o <= pcplus4_i;
        instr_valid_o <= 1'b0;
        instr_o <= NOP_INSTR;
      end
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed stimulus with scoreboarded imem requests and delivered instructions
module tb_pc_fetch_unit;
  logic clk = 0, rst_n;
  logic [31:0] pc_o, pcplus4_i, branch_target_i, imem_req_addr_o, imem_rsp_data_i, instr_o, instr_pc_o;
  logic branch_taken_i, stall_i, imem_req_valid_o, imem_req_ready_i, imem_rsp_valid_i;
  logic instr_valid_o, instr_ready_i, misalign_o;
  int tests = 0, fails = 0;
  logic [31:0] req_q[$];
  logic [63:0] ins_q[$];
  always #5 clk = ~clk;
  assign pcplus4_i = pc_o + 32'd4;
  pc_fetch_unit #(.RESET_PC(32'h100)) dut (
    .clk(clk), .rst_n(rst_n), .pc_o(pc_o), .pcplus4_i(pcplus4_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i), .stall_i(stall_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i), .instr_valid_o(instr_valid_o), .instr_o(instr_o),
    .instr_pc_o(instr_pc_o), .instr_ready_i(instr_ready_i), .misalign_o(misalign_o)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  always @(negedge clk) begin
    if (rst_n && imem_req_valid_o && imem_req_ready_i) begin
      if (req_q.size() == 0) chk("unexpected_req", imem_req_addr_o, 32'hxxxx_xxxx);
      else chk("req_addr", imem_req_addr_o, req_q.pop_front());
    end
    if (rst_n && instr_valid_o && instr_ready_i && !stall_i) begin
      if (ins_q.size() == 0) chk("unexpected_instr", instr_o, 32'hxxxx_xxxx);
      else begin
        logic [63:0] e;
        e = ins_q.pop_front();
        chk("instr_pc", instr_pc_o, e[63:32]);
        chk("instr", instr_o, e[31:0]);
      end
    end
  end
  initial begin
    rst_n = 0; branch_taken_i = 0; branch_target_i = 0; stall_i = 0;
    imem_req_ready_i = 1; imem_rsp_valid_i = 0; imem_rsp_data_i = 0; instr_ready_i = 0;
    repeat (2) step;
    chk("rst_pc", pc_o, 32'h100);
    chk("rst_req_valid", 32'(imem_req_valid_o), 0);
    chk("rst_instr_valid", 32'(instr_valid_o), 0);
    chk("rst_instr", instr_o, 32'h13);
    chk("rst_instr_pc", instr_pc_o, 0);
    chk("rst_misalign", 32'(misalign_o), 0);
    rst_n = 1;
    step;
    chk("boot_req_valid", 32'(imem_req_valid_o), 1);
    req_q.push_back(32'h100);
    step;
    chk("wait_req_valid", 32'(imem_req_valid_o), 0);
    imem_rsp_valid_i = 1; imem_rsp_data_i = 32'hAABBCCDD;
    ins_q.push_back({32'h100, 32'hAABBCCDD});
    step;
    imem_rsp_valid_i = 0;
    chk("hold_valid", 32'(instr_valid_o), 1);
    chk("hold_instr", instr_o, 32'hAABBCCDD);
    instr_ready_i = 1;
    req_q.push_back(32'h104);
    step;
    instr_ready_i = 0;
    chk("adv_pc", pc_o, 32'h104);
    chk("adv_nop", instr_o, 32'h13);
    step;
    branch_taken_i = 1; branch_target_i = 32'h200;
    step;
    branch_taken_i = 0;
    chk("redir_pc", pc_o, 32'h200);
    chk("redir_wait", 32'(imem_req_valid_o), 0);
    imem_rsp_valid_i = 1; imem_rsp_data_i = 32'hDEADBEEF;
    step;
    imem_rsp_valid_i = 0;
    chk("drop_valid", 32'(instr_valid_o), 0);
    chk("drop_req_valid", 32'(imem_req_valid_o), 1);
    req_q.push_back(32'h200);
    step;
    imem_rsp_valid_i = 1; imem_rsp_data_i = 32'h11111111;
    ins_q.push_back({32'h200, 32'h11111111});
    step;
    imem_rsp_valid_i = 0;
    branch_taken_i = 1; branch_target_i = 32'h202;
    step;
    branch_taken_i = 0;
    chk("mis_pulse", 32'(misalign_o), 1);
    chk("mis_pc", pc_o, 32'h200);
    chk("mis_valid", 32'(instr_valid_o), 1);
    step;
    chk("mis_once", 32'(misalign_o), 0);
    stall_i = 1; instr_ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("stall_valid", 32'(instr_valid_o), 1);
      chk("stall_instr", instr_o, 32'h11111111);
      chk("stall_pc", pc_o, 32'h200);
      chk("stall_noreq", 32'(imem_req_valid_o), 0);
    end
    stall_i = 0;
    req_q.push_back(32'h204);
    step;
    instr_ready_i = 0;
    chk("unstall_pc", pc_o, 32'h204);
    step;
    branch_taken_i = 1; branch_target_i = 32'hFFFF_FFFC;
    step;
    branch_taken_i = 0;
    imem_rsp_valid_i = 1; imem_rsp_data_i = 32'h0BAD0BAD;
    step;
    imem_rsp_valid_i = 0;
    req_q.push_back(32'hFFFF_FFFC);
    step;
    imem_rsp_valid_i = 1; imem_rsp_data_i = 32'h22222222;
    ins_q.push_back({32'hFFFF_FFFC, 32'h22222222});
    step;
    imem_rsp_valid_i = 0; instr_ready_i = 1;
    req_q.push_back(32'h0);
    step;
    instr_ready_i = 0;
    chk("wrap_pc", pc_o, 32'h0);
    step;
    rst_n = 0; imem_req_ready_i = 0;
    step;
    chk("mid_rst_pc", pc_o, 32'h100);
    chk("mid_rst_req", 32'(imem_req_valid_o), 0);
    rst_n = 1;
    step;
    imem_rsp_valid_i = 1; imem_rsp_data_i = 32'h33333333;
    step;
    imem_rsp_valid_i = 0;
    chk("stale_valid", 32'(instr_valid_o), 0);
    chk("restart_req", 32'(imem_req_valid_o), 1);
    chk("restart_addr", imem_req_addr_o, 32'h100);
    imem_req_ready_i = 1;
    req_q.push_back(32'h100);
    step;
    imem_rsp_valid_i = 1; imem_rsp_data_i = 32'h44444444;
    ins_q.push_back({32'h100, 32'h44444444});
    step;
    imem_rsp_valid_i = 0; instr_ready_i = 1;
    req_q.push_back(32'h104);
    step;
    instr_ready_i = 0;
    chk("final_pc", pc_o, 32'h104);
    step;
    chk("req_q_drained", req_q.size(), 0);
    chk("ins_q_drained", ins_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
